// File: rtl/pm1_status_tx.sv
// pm1_status_tx: samples the pm1 status vector, queues changed snapshots
// in a 4-deep FIFO and sends each one as a two-byte frame with valid/ready.
module pm1_status_tx (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [12:0] stat_in,
   input  logic        en,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic        clr_ovf,
   output logic        ovf,
   output logic [2:0]  fifo_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      HI,
      LO
   } state_t;

   state_t      state;
   logic [12:0] prev;
   logic [2:0]  seq;
   logic [15:0] mem [4];
   logic [1:0]  rd_ptr;
   logic [1:0]  wr_ptr;
   logic [7:0]  frame_lo;

   logic        push;
   logic        pop;
   logic        full;
   logic        accept;
   logic        drop;
   logic [15:0] head;

   // A pop happens when the sender can start a new frame: from IDLE,
   // or right as the low byte of the current frame is accepted.
   always_comb begin
      head   = mem[rd_ptr];
      push   = en && (stat_in != prev);
      full   = (fifo_cnt == 3'd4);
      pop    = (fifo_cnt != 3'd0) &&
               ((state == IDLE) || ((state == LO) && tx_ready));
      accept = push && (!full || pop);
      drop   = push && full && !pop;
   end

   // Change detector, sequence number and sticky overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev <= 13'd0;
         seq  <= 3'd0;
         ovf  <= 1'b0;
      end else begin
         if (en)
            prev <= stat_in;
         if (accept)
            seq <= seq + 3'd1;
         if (drop)
            ovf <= 1'b1;
         else if (clr_ovf)
            ovf <= 1'b0;
      end
   end

   // Snapshot FIFO; an entry counts as gone on the edge it is popped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++)
            mem[i] <= 16'd0;
         rd_ptr   <= 2'd0;
         wr_ptr   <= 2'd0;
         fifo_cnt <= 3'd0;
      end else begin
         if (accept) begin
            mem[wr_ptr] <= {seq, stat_in};
            wr_ptr      <= wr_ptr + 2'd1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 2'd1;
         fifo_cnt <= fifo_cnt + {2'd0, accept} - {2'd0, pop};
      end
   end

   // Frame sender: high byte {seq,stat[12:8]} then low byte stat[7:0].
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         tx_data  <= 8'd0;
         tx_valid <= 1'b0;
         frame_lo <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  frame_lo <= head[7:0];
                  tx_data  <= head[15:8];
                  tx_valid <= 1'b1;
                  state    <= HI;
               end else begin
                  tx_valid <= 1'b0;
               end
            end
            HI: begin
               if (tx_ready) begin
                  tx_data <= frame_lo;
                  state   <= LO;
               end
            end
            LO: begin
               if (tx_ready) begin
                  if (pop) begin
                     frame_lo <= head[7:0];
                     tx_data  <= head[15:8];
                     state    <= HI;
                  end else begin
                     tx_valid <= 1'b0;
                     state    <= IDLE;
                  end
               end
            end
            default: begin
               tx_valid <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pm1_status_tx.sv
// tb_pm1_status_tx: directed bench for pm1_status_tx with a queue-based
// reference model compared every cycle, plus literal frame checks.
module tb_pm1_status_tx;

   logic        clk;
   logic        rst_n;
   logic [12:0] stat_in;
   logic        en;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        clr_ovf;
   logic        ovf;
   logic [2:0]  fifo_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   pm1_status_tx dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .stat_in  (stat_in),
      .en       (en),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .clr_ovf  (clr_ovf),
      .ovf      (ovf),
      .fifo_cnt (fifo_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // Reference model: snapshot queue plus the bytes still owed for the
   // frame currently on the wire.
   logic [15:0] m_fifo[$];
   logic [7:0]  m_frame[$];
   logic [12:0] m_prev;
   logic [2:0]  m_seq;
   logic        m_ovf;

   always @(posedge clk or negedge rst_n) begin
      logic        hs, mpop, mpush, macc, mdrop;
      logic [15:0] e;
      if (!rst_n) begin
         m_fifo.delete();
         m_frame.delete();
         m_prev = 13'd0;
         m_seq  = 3'd0;
         m_ovf  = 1'b0;
      end else begin
         hs    = (m_frame.size() != 0) && tx_ready;
         mpop  = (m_fifo.size() != 0) &&
                 ((m_frame.size() == 0) || (hs && m_frame.size() == 1));
         mpush = en && (stat_in != m_prev);
         macc  = mpush && ((m_fifo.size() < 4) || mpop);
         mdrop = mpush && !macc;
         if (en)
            m_prev = stat_in;
         if (hs)
            void'(m_frame.pop_front());
         if (mpop) begin
            e = m_fifo.pop_front();
            m_frame.push_back(e[15:8]);
            m_frame.push_back(e[7:0]);
         end
         if (macc) begin
            m_fifo.push_back({m_seq, stat_in});
            m_seq = m_seq + 3'd1;
         end
         if (mdrop)
            m_ovf = 1'b1;
         else if (clr_ovf)
            m_ovf = 1'b0;
      end
   end

   // Bytes actually taken by the downstream side.
   logic [7:0] log_q[$];
   always @(posedge clk)
      if (rst_n && tx_valid && tx_ready)
         log_q.push_back(tx_data);

   // Per-cycle compare against the model, plus stall stability.
   logic       l_v, l_r;
   logic [7:0] l_d;
   initial begin
      l_v = 1'b0;
      l_r = 1'b0;
      l_d = 8'd0;
   end
   always @(negedge clk) begin
      check("fifo_cnt", 32'(fifo_cnt), 32'(m_fifo.size()));
      check("tx_valid", 32'(tx_valid), 32'(m_frame.size() != 0));
      check("ovf", 32'(ovf), 32'(m_ovf));
      if (tx_valid && m_frame.size() != 0)
         check("tx_data", 32'(tx_data), 32'(m_frame[0]));
      if (rst_n && l_v && !l_r) begin
         check("stall_valid", 32'(tx_valid), 32'(l_v));
         check("stall_data", 32'(tx_data), 32'(l_d));
      end
      l_v = rst_n && tx_valid;
      l_r = tx_ready;
      l_d = tx_data;
   end

   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
   endtask

   task automatic check_log(string name, logic [7:0] exp[$]);
      check({name, "_len"}, 32'(log_q.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < log_q.size(); i++)
         check(name, 32'(log_q[i]), 32'(exp[i]));
   endtask

   initial begin
      rst_n    = 1'b0;
      stat_in  = 13'd0;
      en       = 1'b0;
      tx_ready = 1'b1;
      clr_ovf  = 1'b0;
      #1;
      check("rst_valid", 32'(tx_valid), 32'd0);
      check("rst_data", 32'(tx_data), 32'd0);
      check("rst_cnt", 32'(fifo_cnt), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      tick(2);

      // Single snapshot 1ABC: 1A then BC then idle.
      rst_n   = 1'b1;
      en      = 1'b1;
      stat_in = 13'h1ABC;
      tick();
      check("lat_cnt", 32'(fifo_cnt), 32'd1);
      check("lat_valid", 32'(tx_valid), 32'd0);
      tick();
      check("hi_valid", 32'(tx_valid), 32'd1);
      check("hi_byte", 32'(tx_data), 32'h1A);
      check("hi_cnt", 32'(fifo_cnt), 32'd0);
      tick();
      check("lo_byte", 32'(tx_data), 32'hBC);
      tick();
      check("end_valid", 32'(tx_valid), 32'd0);

      // Stable input yields one frame; a change yields the next.
      do_reset();
      log_q.delete();
      stat_in = 13'h0005;
      tick(12);
      check_log("stable", '{8'h00, 8'h05});
      stat_in = 13'h0006;
      tick(6);
      check_log("second", '{8'h00, 8'h05, 8'h20, 8'h06});

      // Overflow with a stalled receiver, then in-order drain.
      tx_ready = 1'b0;
      do_reset();
      log_q.delete();
      for (int i = 1; i <= 6; i++) begin
         stat_in = 13'(i);
         tick();
      end
      check("full_cnt", 32'(fifo_cnt), 32'd4);
      check("full_ovf", 32'(ovf), 32'd1);
      check("full_byte", 32'(tx_data), 32'h00);
      en       = 1'b0;
      tx_ready = 1'b1;
      tick(12);
      check_log("drain", '{8'h00, 8'h01, 8'h20, 8'h02, 8'h40, 8'h03,
                           8'h60, 8'h04, 8'h80, 8'h05});
      en      = 1'b1;
      stat_in = 13'h0007;
      tick(2);
      check("seq_keep", 32'(tx_data), 32'hA0);
      tick(4);
      check("ovf_sticky", 32'(ovf), 32'd1);

      // Clear, then a drop on the same edge as clr_ovf.
      clr_ovf = 1'b1;
      tick();
      check("ovf_clr", 32'(ovf), 32'd0);
      clr_ovf  = 1'b0;
      tx_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         stat_in = 13'(8 + i);
         clr_ovf = (i == 5);
         tick();
      end
      check("set_wins", 32'(ovf), 32'd1);
      en = 1'b0;
      tick();
      check("clr_after", 32'(ovf), 32'd0);
      clr_ovf  = 1'b0;
      tx_ready = 1'b1;
      tick(12);

      // Alternating ready with three queued snapshots.
      tx_ready = 1'b0;
      do_reset();
      log_q.delete();
      en = 1'b1;
      stat_in = 13'h1F01;
      tick();
      stat_in = 13'h0A0A;
      tick();
      stat_in = 13'h1555;
      tick();
      en = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tx_ready = (i % 2 == 0);
         tick();
      end
      check_log("toggle", '{8'h1F, 8'h01, 8'h2A, 8'h0A, 8'h55, 8'h55});

      // Reset during the low byte with two snapshots queued.
      tx_ready = 1'b0;
      do_reset();
      en = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         stat_in = 13'(i);
         tick();
      end
      en = 1'b0;
      log_q.delete();
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      check("mid_lo", 32'(tx_data), 32'h01);
      check("mid_cnt", 32'(fifo_cnt), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(tx_valid), 32'd0);
      check("arst_cnt", 32'(fifo_cnt), 32'd0);
      stat_in  = 13'd0;
      en       = 1'b1;
      tx_ready = 1'b1;
      tick(2);
      rst_n = 1'b1;
      tick(5);
      check("quiet_len", 32'(log_q.size()), 32'd1);
      check("quiet_valid", 32'(tx_valid), 32'd0);
      stat_in = 13'h0003;
      tick(2);
      check("resume_valid", 32'(tx_valid), 32'd1);
      check("resume_byte", 32'(tx_data), 32'h00);
      tick(4);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
